// File: rtl/imem_loader_if.sv
// Loader bundle: byte stream in, instruction-memory write port out, plus core release/status and re-arm.
interface imem_loader_if #(
  parameter int ADDR_WIDTH = 10
);
  logic                  InValid;
  logic [7:0]            InData;
  logic                  InReady;
  logic                  IMWrEn;
  logic [ADDR_WIDTH-1:0] IMWrAddr;
  logic [31:0]           IMWrData;
  logic                  CoreReset;
  logic                  Done;
  logic                  Error;
  logic [31:0]           WordCount;
  logic                  Reload;

  modport master (
    output InValid, InData, Reload,
    input  InReady, IMWrEn, IMWrAddr, IMWrData, CoreReset, Done, Error, WordCount
  );

  modport slave (
    input  InValid, InData, Reload,
    output InReady, IMWrEn, IMWrAddr, IMWrData, CoreReset, Done, Error, WordCount
  );
endinterface

// File: rtl/imem_loader.sv
// Boot loader: big-endian byte stream -> imem words, core held in reset until load completes; write strobe
// on the 4th-byte edge, release one cycle later; no back-pressure while loading. Trailer check: IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter int ADDR_WIDTH = 10,
  parameter int BASE_ADDR  = 0
) (
  input logic          Clk,
  input logic          Reset,
  imem_loader_if.slave bus
);
  localparam logic [2:0] S_HDR   = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam logic [2:0] S_CHK   = 3'd2;
`endif
  localparam logic [2:0] S_DONE  = 3'd3;
  localparam logic [2:0] S_ERROR = 3'd4;

  localparam logic [32:0]           CAPACITY = 33'd1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] BASE     = ADDR_WIDTH'(BASE_ADDR);

  logic [2:0]            state;
  logic [1:0]            byte_cnt;
  logic [23:0]           shift_dat;
  logic [31:0]           len;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic                  finish_pend;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [31:0]           csum;
`endif

  logic        accept;
  logic        word_done;
  logic [31:0] word;

  assign accept    = bus.InValid && bus.InReady;
  assign word_done = accept && (byte_cnt == 2'd3);
  assign word      = {shift_dat, bus.InData};

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state         <= S_HDR;
      byte_cnt      <= 2'd0;
      shift_dat     <= 24'd0;
      len           <= 32'd0;
      wr_addr       <= BASE;
      finish_pend   <= 1'b0;
      bus.InReady   <= 1'b0;
      bus.IMWrEn    <= 1'b0;
      bus.IMWrAddr  <= '0;
      bus.IMWrData  <= 32'd0;
      bus.CoreReset <= 1'b1;
      bus.Done      <= 1'b0;
      bus.Error     <= 1'b0;
      bus.WordCount <= 32'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum          <= 32'd0;
`endif
    end else begin
      bus.IMWrEn <= 1'b0;
      if (accept) begin
        byte_cnt  <= byte_cnt + 2'd1;
        shift_dat <= {shift_dat[15:0], bus.InData};
      end

      // The final word's strobe cycle completes before the core is released.
      if (finish_pend) begin
        finish_pend   <= 1'b0;
        state         <= S_DONE;
        bus.CoreReset <= 1'b0;
        bus.Done      <= 1'b1;
      end else begin
        case (state)
          S_HDR: begin
            bus.InReady <= 1'b1;
            if (word_done) begin
              len <= word;
              if (word == 32'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                state <= S_CHK;
`else
                finish_pend <= 1'b1;
                bus.InReady <= 1'b0;
`endif
              end else if ({1'b0, word} > CAPACITY) begin
                state       <= S_ERROR;
                bus.Error   <= 1'b1;
                bus.InReady <= 1'b0;
              end else begin
                state <= S_LOAD;
              end
            end
          end

          S_LOAD: begin
            if (word_done) begin
              bus.IMWrEn    <= 1'b1;
              bus.IMWrAddr  <= wr_addr;
              bus.IMWrData  <= word;
              wr_addr       <= wr_addr + 1'b1;
              bus.WordCount <= bus.WordCount + 32'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
              csum          <= csum ^ word;
`endif
              if (bus.WordCount + 32'd1 == len) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                state <= S_CHK;
`else
                finish_pend <= 1'b1;
                bus.InReady <= 1'b0;
`endif
              end
            end
          end

`ifdef IMEM_LOADER_CHECKSUM_EN
          S_CHK: begin
            if (word_done) begin
              bus.InReady <= 1'b0;
              if (word == csum) begin
                finish_pend <= 1'b1;
              end else begin
                state     <= S_ERROR;
                bus.Error <= 1'b1;
              end
            end
          end
`endif

          S_DONE, S_ERROR: begin
            if (bus.Reload) begin
              state         <= S_HDR;
              bus.InReady   <= 1'b1;
              bus.CoreReset <= 1'b1;
              bus.Done      <= 1'b0;
              bus.Error     <= 1'b0;
              bus.WordCount <= 32'd0;
              byte_cnt      <= 2'd0;
              wr_addr       <= BASE;
`ifdef IMEM_LOADER_CHECKSUM_EN
              csum          <= 32'd0;
`endif
            end
          end

          default: state <= S_HDR;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: scoreboard of expected imem writes plus release/error/reset timing checks.
module tb_imem_loader;
  localparam int AW = 10;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   dat;
  } wr_t;

  logic Clk = 1'b0;
  logic Reset;
  always #5 Clk = ~Clk;

  imem_loader_if #(.ADDR_WIDTH(AW)) bus();

  imem_loader #(.ADDR_WIDTH(AW), .BASE_ADDR(0)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  int            checks = 0;
  int            failures = 0;
  wr_t           exp_q[$];
  wr_t           got_exp;
  logic [AW-1:0] next_addr;
  bit            gaps;
  logic [31:0]   csum;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  always @(negedge Clk) begin
    if (Reset === 1'b1 && bus.IMWrEn === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", 64'd1, 64'd0);
      end else begin
        got_exp = exp_q.pop_front();
        check("wr_addr", 64'(bus.IMWrAddr), 64'(got_exp.addr));
        check("wr_data", 64'(bus.IMWrData), 64'(got_exp.dat));
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int gap;
    int budget;
    gap = gaps ? int'($urandom_range(0, 2)) : 0;
    budget = 0;
    @(negedge Clk);
    repeat (gap) begin
      bus.InValid = 1'b0;
      @(negedge Clk);
    end
    bus.InValid = 1'b1;
    bus.InData  = b;
    while (!bus.InReady && budget < 50) begin
      @(negedge Clk);
      budget++;
    end
    if (!bus.InReady) begin
      check("ready_timeout", 64'd0, 64'd1);
      bus.InValid = 1'b0;
      return;
    end
    @(posedge Clk);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8]);
  endtask

  task automatic push_word(input logic [31:0] w);
    wr_t e;
    e.addr = next_addr;
    e.dat  = w;
    exp_q.push_back(e);
    next_addr = next_addr + 1'b1;
    send_word(w);
  endtask

  task automatic expect_release(input string tag);
    @(negedge Clk);
    bus.InValid = 1'b0;
    check({tag, "_rdy_fall"}, 64'(bus.InReady), 64'd0);
    check({tag, "_done_early"}, 64'(bus.Done), 64'd0);
    check({tag, "_core_held"}, 64'(bus.CoreReset), 64'd1);
    @(negedge Clk);
    check({tag, "_done"}, 64'(bus.Done), 64'd1);
    check({tag, "_core_rel"}, 64'(bus.CoreReset), 64'd0);
  endtask

  task automatic expect_error(input string tag);
    @(negedge Clk);
    bus.InValid = 1'b0;
    check({tag, "_err"}, 64'(bus.Error), 64'd1);
    check({tag, "_rdy"}, 64'(bus.InReady), 64'd0);
    check({tag, "_core"}, 64'(bus.CoreReset), 64'd1);
    check({tag, "_done"}, 64'(bus.Done), 64'd0);
  endtask

  task automatic reload(input string tag);
    @(negedge Clk);
    bus.Reload = 1'b1;
    @(negedge Clk);
    bus.Reload = 1'b0;
    check({tag, "_done_clr"}, 64'(bus.Done), 64'd0);
    check({tag, "_err_clr"}, 64'(bus.Error), 64'd0);
    check({tag, "_core"}, 64'(bus.CoreReset), 64'd1);
    check({tag, "_rdy"}, 64'(bus.InReady), 64'd1);
    check({tag, "_cnt"}, 64'(bus.WordCount), 64'd0);
    next_addr = '0;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_rdy"}, 64'(bus.InReady), 64'd0);
    check({tag, "_wren"}, 64'(bus.IMWrEn), 64'd0);
    check({tag, "_addr"}, 64'(bus.IMWrAddr), 64'd0);
    check({tag, "_data"}, 64'(bus.IMWrData), 64'd0);
    check({tag, "_core"}, 64'(bus.CoreReset), 64'd1);
    check({tag, "_done"}, 64'(bus.Done), 64'd0);
    check({tag, "_err"}, 64'(bus.Error), 64'd0);
    check({tag, "_cnt"}, 64'(bus.WordCount), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w;
    Reset = 1'b0;
    bus.InValid = 1'b0;
    bus.InData = 8'd0;
    bus.Reload = 1'b0;
    gaps = 1'b0;
    next_addr = '0;
    repeat (3) @(negedge Clk);
    check_reset("rst");
    Reset = 1'b1;
    @(negedge Clk);
    check("rdy_after_rst", 64'(bus.InReady), 64'd1);
    check("core_after_rst", 64'(bus.CoreReset), 64'd1);

    // Three-word program
    send_word(32'd3);
    push_word(32'h20020005);
    push_word(32'h20030007);
    push_word(32'h00431020);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_word(32'h20020005 ^ 32'h20030007 ^ 32'h00431020);
`endif
    expect_release("t3");
    check("t3_count", 64'(bus.WordCount), 64'd3);
    check("t3_q", 64'(exp_q.size()), 64'd0);
    reload("rl1");

    // Empty image
    send_word(32'd0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_word(32'd0);
`endif
    expect_release("n0");
    check("n0_count", 64'(bus.WordCount), 64'd0);
    reload("rl2");

    // Oversized header
    send_word(32'h00000401);
    expect_error("ovf");
    repeat (3) @(negedge Clk);
    check("ovf_err_hold", 64'(bus.Error), 64'd1);
    check("ovf_core_hold", 64'(bus.CoreReset), 64'd1);
    reload("rl3");

    // Full-capacity image
    send_word(32'd1024);
    csum = 32'd0;
    for (int i = 0; i < 1024; i++) begin
      w = $urandom;
      csum = csum ^ w;
      push_word(w);
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_word(csum);
`endif
    expect_release("full");
    check("full_count", 64'(bus.WordCount), 64'd1024);
    reload("rl4");

    // Reset after 6 bytes with ragged valid, then fresh load
    gaps = 1'b1;
    send_word(32'd5);
    send_byte(8'hAB);
    send_byte(8'hCD);
    @(negedge Clk);
    bus.InValid = 1'b0;
    Reset = 1'b0;
    @(negedge Clk);
    check_reset("midrst");
    Reset = 1'b1;
    next_addr = '0;
    send_word(32'd2);
    push_word(32'hAABBCCDD);
    push_word(32'h01020304);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_word(32'hAABBCCDD ^ 32'h01020304);
`endif
    expect_release("fresh");
    check("fresh_count", 64'(bus.WordCount), 64'd2);
    gaps = 1'b0;
    reload("rl5");

`ifdef IMEM_LOADER_CHECKSUM_EN
    send_word(32'd2);
    push_word(32'h11111111);
    push_word(32'h22222222);
    send_word(32'h33333333);
    expect_release("ck_ok");
    reload("rl6");
    send_word(32'd2);
    push_word(32'h11111111);
    push_word(32'h22222222);
    send_word(32'h33333334);
    expect_error("ck_bad");
    reload("rl7");
`endif

    repeat (3) @(negedge Clk);
    check("final_q", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time writer for the pipelined MIPS datapath's instruction memory. It accepts a byte stream over a valid/ready handshake and assembles big-endian 32-bit words. It writes them into the instruction memory's write port and holds the datapath in reset until the program image is fully loaded. It sits between the host/serial front end and the `TopDatapath` instruction memory, and drives the datapath's active-high reset.

## Interface
Parameters:
- `ADDR_WIDTH`, 10: instruction-memory word-address width; capacity is 2^ADDR_WIDTH words.
- `BASE_ADDR`, 0: word address of the first program word.

Ports:
- `Clk`  in  1  system clock; one clock domain.
- `Reset`  in  1  asynchronous, active-low reset.
- `InValid`  in  1  byte on `InData` is valid.
- `InData`  in  8  stream byte.
- `InReady`  out  1  loader accepts a byte this cycle.
- `IMWrEn`  out  1  single-cycle instruction-memory write strobe.
- `IMWrAddr`  out  ADDR_WIDTH  word address of the write.
- `IMWrData`  out  32  instruction word.
- `CoreReset`  out  1  active-high reset to the datapath.
- `Done`  out  1  image loaded; core released.
- `Error`  out  1  image rejected.
- `WordCount`  out  32  program words written so far.
- `Reload`  in  1  re-arm request; honoured only in DONE or ERROR.

## Operation
- A byte is accepted on a rising `Clk` when `InValid && InReady`. The first byte of each word is bits [31:24] and the fourth is bits [7:0]. A 2-bit byte counter wraps after each word.
- States: HDR, LOAD, CHK (macro only), DONE, ERROR.
- HDR: the first word is the program length N.
  - N == 0: go to DONE, or to CHK when checksum is enabled.
  - N > 2^ADDR_WIDTH: go to ERROR.
  - Otherwise: go to LOAD.
- LOAD: each completed word k (0-based) is written to `BASE_ADDR + k`, wrapping modulo 2^ADDR_WIDTH. `WordCount` increments with each write.
  - After word N-1 completes, go to DONE, or to CHK when checksum is enabled.
- DONE: `CoreReset`=0 and `Done`=1. The stream is not accepted.
- ERROR: `Error`=1, `CoreReset` stays 1, and the stream is not accepted.
- `Reload`=1 in DONE or ERROR returns to HDR on the next edge: `CoreReset`=1, `Done`/`Error`/`WordCount`/byte counter cleared. `Reload` is ignored in all other states.
- Reset mid-load: all state returns to reset values. Instruction memory contents are not cleared; the next image overwrites them.

## Timing
- Reset values: `InReady`=0, `IMWrEn`=0, `IMWrAddr`=0, `IMWrData`=0, `CoreReset`=1, `Done`=0, `Error`=0, `WordCount`=0, state HDR.
- `InReady` is registered. It rises on the first edge after `Reset` deasserts and is 1 throughout HDR, LOAD and CHK.
- `InReady` falls on the edge that accepts the final byte of the image (header with N==0, last program word, or trailer). It also falls on the edge that detects an error.
- Write latency: `IMWrEn`, `IMWrAddr` and `IMWrData` are registered. They are valid for exactly one cycle, starting on the edge that accepts the word's 4th byte. There is no back-pressure during LOAD; back-to-back words every 4 cycles are sustained.
- Release: DONE, `CoreReset`=0 and `Done`=1 take effect on the edge after the final `IMWrEn` cycle. The last word is therefore committed before the core leaves reset.
- For N==0, DONE is entered 1 cycle after the header's 4th byte.
- All outputs are registered; none are combinational from the inputs.

## Configuration
- `IMEM_LOADER_CHECKSUM_EN` defined:
  - After the last program word, the CHK state accepts one trailer word.
  - The trailer must equal the XOR of all N program words (0 when N==0).
  - Match: DONE on the edge after the trailer's 4th byte. Mismatch: ERROR on the same edge.
  - The trailer is never written to instruction memory.
- Not defined: there is no CHK state and no trailer is expected; the load ends after word N-1.

## Test plan
- Header 3, then words 0x20020005, 0x20030007, 0x00431020 -> three `IMWrEn` pulses at addresses 0, 1, 2 with those data. `WordCount`=3, then `CoreReset`=0 and `Done`=1 one cycle after the last pulse.
- Header 0 -> no write; `Done`=1 one cycle after the header's 4th byte. With the macro, trailer 0x00000000 is required first.
- Header 0x00000401 with `ADDR_WIDTH`=10 -> `Error`=1, `InReady`=0, `CoreReset` stays 1. `Reload` pulse -> HDR, `Error`=0, `InReady`=1.
- `InValid` toggled randomly mid-word and `Reset` asserted after 6 bytes -> all outputs at reset values. A fresh header then loads from `BASE_ADDR`.
- Macro on, words 0x11111111 and 0x22222222 with trailer 0x33333333 -> `Done`=1. Trailer 0x33333334 -> `Error`=1 and `CoreReset`=1.
